// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with show-ahead read data,
// occupancy count, programmable almost-full/almost-empty thresholds and
// sticky overflow/underflow error flags. Status flags are registered and
// loaded from the next-state pointers/count, so they update one edge after
// the operation that causes them and never see add_fifo/pop_fifo combinationally.
module fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 2,
    parameter int AF_LEVEL   = (2 ** ADDR_BITS) - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  add_fifo,
    input  logic                  pop_fifo,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] PTR_ONE_C = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0] AF_LVL_C  = AF_LEVEL[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] AE_LVL_C  = AE_LEVEL[ADDR_BITS:0];

    // Threshold legality is fixed at elaboration; an illegal set stops the build.
    if ((ADDR_BITS < 1) || (AE_LEVEL < 0) || (AE_LEVEL >= AF_LEVEL) || (AF_LEVEL > DEPTH)) begin : g_param_illegal
        $fatal(1, "fifo_param: need ADDR_BITS>=1 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_BITS:0]    wr_ptr_r;
    logic [ADDR_BITS:0]    rd_ptr_r;

    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic [ADDR_BITS:0]    wr_ptr_nxt_s;
    logic [ADDR_BITS:0]    rd_ptr_nxt_s;
    logic [ADDR_BITS:0]    count_nxt_s;
    logic                  empty_nxt_s;
    logic                  full_nxt_s;
    logic                  af_nxt_s;
    logic                  ae_nxt_s;
    logic                  ovf_nxt_s;
    logic                  unf_nxt_s;

    // Show-ahead read: head entry addressed by the low read-pointer bits.
    assign data_out = mem_r[rd_ptr_r[ADDR_BITS-1:0]];

    // Accept rules, next pointers/count and next flag values.
    always_comb begin
        push_ok_s    = add_fifo & (~fifo_full | pop_fifo);
        pop_ok_s     = pop_fifo & ~fifo_empty;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count;
        ovf_nxt_s    = overflow;
        unf_nxt_s    = underflow;

        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE_C;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE_C;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count + PTR_ONE_C;
            2'b01:   count_nxt_s = count - PTR_ONE_C;
            default: count_nxt_s = count;
        endcase

        // Setting an error wins over clearing it in the same cycle.
        if (add_fifo & ~push_ok_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_err) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = overflow;
        end

        if (pop_fifo & ~pop_ok_s) begin
            unf_nxt_s = 1'b1;
        end else if (clr_err) begin
            unf_nxt_s = 1'b0;
        end else begin
            unf_nxt_s = underflow;
        end

        empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
        full_nxt_s  = (wr_ptr_nxt_s[ADDR_BITS] != rd_ptr_nxt_s[ADDR_BITS]) &&
                      (wr_ptr_nxt_s[ADDR_BITS-1:0] == rd_ptr_nxt_s[ADDR_BITS-1:0]);
        af_nxt_s    = (count_nxt_s >= AF_LVL_C);
        ae_nxt_s    = (count_nxt_s <= AE_LVL_C);
    end

    // Pointer, count and flag registers; reset overrides every request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r     <= {(ADDR_BITS+1){1'b0}};
            rd_ptr_r     <= {(ADDR_BITS+1){1'b0}};
            count        <= {(ADDR_BITS+1){1'b0}};
            fifo_empty   <= 1'b1;
            fifo_full    <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count        <= count_nxt_s;
            fifo_empty   <= empty_nxt_s;
            fifo_full    <= full_nxt_s;
            almost_full  <= af_nxt_s;
            almost_empty <= ae_nxt_s;
            overflow     <= ovf_nxt_s;
            underflow    <= unf_nxt_s;
        end
    end

    // Storage write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst && push_ok_s) begin
            mem_r[wr_ptr_r[ADDR_BITS-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed scenarios plus randomised
// traffic on three parameter sets, all compared against a queue model.
module tb_fifo_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        add;
    logic        pop;
    logic        clr;
    logic [31:0] din;

    logic [15:0] d0;
    logic [0:0]  d1;
    logic [31:0] d2;
    logic [2:0]  c0;
    logic [1:0]  c1;
    logic [3:0]  c2;
    logic [5:0]  f0, f1, f2;   // {ovf, unf, ae, af, full, empty}

    logic [31:0] obs_data;
    logic [31:0] obs_count;
    logic [5:0]  obs_flags;

    int          sel;
    int          depth_m;
    int          af_m;
    int          ae_m;
    logic [31:0] mask_m;
    logic [31:0] q[$];
    bit          ovf_m;
    bit          unf_m;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(16), .ADDR_BITS(2)) u_f0 (
        .clk(clk), .rst(rst), .data_in(din[15:0]), .add_fifo(add), .pop_fifo(pop),
        .clr_err(clr), .data_out(d0), .fifo_empty(f0[0]), .fifo_full(f0[1]),
        .almost_full(f0[2]), .almost_empty(f0[3]), .count(c0),
        .overflow(f0[5]), .underflow(f0[4]));

    fifo_param #(.DATA_WIDTH(1), .ADDR_BITS(1), .AF_LEVEL(2), .AE_LEVEL(1)) u_f1 (
        .clk(clk), .rst(rst), .data_in(din[0:0]), .add_fifo(add), .pop_fifo(pop),
        .clr_err(clr), .data_out(d1), .fifo_empty(f1[0]), .fifo_full(f1[1]),
        .almost_full(f1[2]), .almost_empty(f1[3]), .count(c1),
        .overflow(f1[5]), .underflow(f1[4]));

    fifo_param #(.DATA_WIDTH(32), .ADDR_BITS(3), .AF_LEVEL(6), .AE_LEVEL(2)) u_f2 (
        .clk(clk), .rst(rst), .data_in(din), .add_fifo(add), .pop_fifo(pop),
        .clr_err(clr), .data_out(d2), .fifo_empty(f2[0]), .fifo_full(f2[1]),
        .almost_full(f2[2]), .almost_empty(f2[3]), .count(c2),
        .overflow(f2[5]), .underflow(f2[4]));

    // Route the instance under test onto common observation signals.
    always_comb begin
        obs_data  = 32'h0;
        obs_count = 32'h0;
        obs_flags = 6'h0;
        case (sel)
            0: begin obs_data = {16'h0, d0}; obs_count = {29'h0, c0}; obs_flags = f0; end
            1: begin obs_data = {31'h0, d1}; obs_count = {30'h0, c1}; obs_flags = f1; end
            default: begin obs_data = d2; obs_count = {28'h0, c2}; obs_flags = f2; end
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (inst %0d): observed 0x%0h expected 0x%0h", tag, sel, obs, exp);
        end
    endtask

    // Compare every output against the queue model.
    task automatic check_all();
        int sz;
        sz = q.size();
        check_val("count", obs_count, 32'(sz));
        check_val("fifo_empty", 32'(obs_flags[0]), 32'(sz == 0));
        check_val("fifo_full", 32'(obs_flags[1]), 32'(sz == depth_m));
        check_val("almost_full", 32'(obs_flags[2]), 32'(sz >= af_m));
        check_val("almost_empty", 32'(obs_flags[3]), 32'(sz <= ae_m));
        check_val("underflow", 32'(obs_flags[4]), 32'(unf_m));
        check_val("overflow", 32'(obs_flags[5]), 32'(ovf_m));
        if (sz > 0) check_val("data_out", obs_data, q[0]);
    endtask

    // One clock with the given requests; model updated from the rules.
    task automatic step(input bit a, input bit p, input bit c, input logic [31:0] d);
        int sz;
        bit full_m, push_ok, pop_ok;
        rst = 1'b1; add = a; pop = p; clr = c; din = d;
        sz = q.size();
        full_m  = (sz == depth_m);
        push_ok = a && (!full_m || p);
        pop_ok  = p && (sz != 0);
        if (pop_ok) void'(q.pop_front());
        if (push_ok) q.push_back(d & mask_m);
        if (a && !push_ok) ovf_m = 1'b1; else if (c) ovf_m = 1'b0;
        if (p && !pop_ok) unf_m = 1'b1; else if (c) unf_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        add = 1'b0; pop = 1'b0; clr = 1'b0;
        check_all();
    endtask

    // One reset cycle with requests active to confirm reset priority.
    task automatic do_reset(input bit a, input bit p, input bit c);
        rst = 1'b0; add = a; pop = p; clr = c; din = $urandom;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; add = 1'b0; pop = 1'b0; clr = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        check_all();
    endtask

    task automatic set_phase(input int s, input int ab, input int w, input int af, input int ae);
        sel     = s;
        depth_m = 1 << ab;
        mask_m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        af_m    = af;
        ae_m    = ae;
        do_reset(1'b1, 1'b1, 1'b0);
    endtask

    task automatic random_run(input int n);
        int pp, pq;
        for (int i = 0; i < n; i++) begin
            pp = (i % 60 < 30) ? 70 : 35;
            pq = (i % 60 < 30) ? 35 : 70;
            if ($urandom_range(0, 99) < 2) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                step(1'($urandom_range(0, 99) < pp), 1'($urandom_range(0, 99) < pq),
                     1'($urandom_range(0, 99) < 8), $urandom);
            end
        end
    endtask

    initial begin
        rst = 1'b0; add = 1'b0; pop = 1'b0; clr = 1'b0; din = 32'h0;
        sel = 0; ovf_m = 1'b0; unf_m = 1'b0;
        @(negedge clk);

        // Reset then idle
        set_phase(0, 2, 16, 3, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("rst_empty", 32'(obs_flags[0]), 32'd1);
        check_val("rst_count", obs_count, 32'd0);

        // Fill 4 entries, then a refused 5th push
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'hA000 + 32'(i));
            check_val("fill_count", obs_count, 32'(i + 1));
        end
        check_val("fill_full", 32'(obs_flags[1]), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'hA004);
        check_val("ovf_set", 32'(obs_flags[5]), 32'd1);
        check_val("ovf_keep_cnt", obs_count, 32'd4);

        // Clear racing a refused push: set wins; then clr alone clears
        step(1'b1, 1'b0, 1'b1, 32'hA005);
        check_val("ovf_set_wins", 32'(obs_flags[5]), 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        check_val("ovf_cleared", 32'(obs_flags[5]), 32'd0);

        // Push+pop while full: new entry goes last
        step(1'b1, 1'b1, 1'b0, 32'hA006);
        check_val("full_pp_cnt", obs_count, 32'd4);
        check_val("full_pp_head", obs_data, 32'hA001);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("pop_a002", obs_data, 32'hA002);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("pop_a003", obs_data, 32'hA003);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check_val("pop_a006", obs_data, 32'hA006);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Push+pop while empty: push accepted, pop refused
        step(1'b1, 1'b1, 1'b0, 32'hB000);
        check_val("empty_pp_cnt", obs_count, 32'd1);
        check_val("empty_pp_unf", 32'(obs_flags[4]), 32'd1);
        check_val("empty_pp_data", obs_data, 32'hB000);
        step(1'b0, 1'b0, 1'b1, 32'h0);

        // Wrap-around at occupancy 2
        step(1'b1, 1'b0, 1'b0, 32'hB001);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, $urandom);
        check_val("wrap_count", obs_count, 32'd2);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Reset with 3 entries stored
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'hC000 + 32'(i));
        do_reset(1'b1, 1'b1, 1'b1);
        check_val("midrst_count", obs_count, 32'd0);
        check_val("midrst_empty", 32'(obs_flags[0]), 32'd1);

        random_run(400);

        // Parameter sweep
        set_phase(1, 1, 1, 2, 1);
        random_run(300);
        set_phase(2, 3, 32, 6, 2);
        random_run(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
